// File: rtl/weight_col_loader.sv
// rtl/weight_col_loader.sv - weight-preload transmitter for one systolic-array column
// Optional feature macro: WLOAD_ZERO_PAD_EN (short tiles are zero-padded instead of discarded)
module weight_col_loader #(
  parameter int W_BITWIDTH = 8,
  parameter int ROWS       = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [W_BITWIDTH-1:0] s_data,
  input  logic                  s_last,
  input  logic                  switch_allow,
  output logic                  W_en,
  output logic [W_BITWIDTH-1:0] W_out,
  output logic                  switch_out,
  output logic                  busy,
  output logic                  err
);

  localparam int CW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [CW-1:0] LAST = CW'(ROWS - 1);

  typedef enum logic [2:0] {
    COLLECT = 3'd0,
    SHIFT   = 3'd1,
    SETTLE  = 3'd2,
    ARMED   = 3'd3,
    SWITCH  = 3'd4
  } state_t;

  state_t                state, state_n;
  logic [CW-1:0]         count, count_n;
  logic [CW-1:0]         settle, settle_n;
  logic                  w_en_n;
  logic [W_BITWIDTH-1:0] w_out_n;
  logic                  switch_n;
  logic                  err_n;
  logic [CW-1:0]         rd_idx;
  logic [W_BITWIDTH-1:0] wbuf [ROWS];

  logic accept;
  assign accept  = s_valid & s_ready;
  assign s_ready = (state == COLLECT);
  assign busy    = (state != COLLECT) | (count != '0);

  // Index of the word driven on the next shift cycle (count is the current shift index)
  assign rd_idx = LAST - count - CW'(1);

  // Tile buffer: store accepted words; a zero-padded short tile clears the unused tail
  always_ff @(posedge clk) begin
    if (accept) begin
      wbuf[count] <= s_data;
`ifdef WLOAD_ZERO_PAD_EN
      if (s_last && (count != LAST)) begin
        for (int j = 0; j < ROWS; j++) begin
          if (j > int'(count)) begin
            wbuf[j] <= '0;
          end
        end
      end
`endif
    end
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= COLLECT;
      count      <= '0;
      settle     <= '0;
      W_en       <= 1'b0;
      W_out      <= '0;
      switch_out <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_n;
      count      <= count_n;
      settle     <= settle_n;
      W_en       <= w_en_n;
      W_out      <= w_out_n;
      switch_out <= switch_n;
      err        <= err_n;
    end
  end

  // Next-state and next-output decode; the first shift word is taken straight from the
  // final handshake because it is written into the buffer on the same edge
  always_comb begin
    state_n  = state;
    count_n  = count;
    settle_n = settle;
    w_en_n   = 1'b0;
    w_out_n  = '0;
    switch_n = 1'b0;
    err_n    = err;
    unique case (state)
      COLLECT: begin
        if (accept) begin
          if (count == LAST) begin
            state_n = SHIFT;
            count_n = '0;
            w_en_n  = 1'b1;
            w_out_n = s_data;
            if (!s_last) begin
              err_n = 1'b1;
            end
          end else if (s_last) begin
`ifdef WLOAD_ZERO_PAD_EN
            state_n = SHIFT;
            count_n = '0;
            w_en_n  = 1'b1;
            w_out_n = '0;
`else
            err_n   = 1'b1;
            count_n = '0;
`endif
          end else begin
            count_n = count + CW'(1);
          end
        end
      end
      SHIFT: begin
        if (count == LAST) begin
          state_n  = SETTLE;
          count_n  = '0;
          settle_n = '0;
        end else begin
          w_en_n  = 1'b1;
          w_out_n = wbuf[rd_idx];
          count_n = count + CW'(1);
        end
      end
      SETTLE: begin
        if (settle == LAST) begin
          state_n  = ARMED;
          settle_n = '0;
        end else begin
          settle_n = settle + CW'(1);
        end
      end
      ARMED: begin
        if (switch_allow) begin
          state_n  = SWITCH;
          switch_n = 1'b1;
        end
      end
      SWITCH: begin
        state_n = COLLECT;
      end
      default: begin
        state_n = COLLECT;
      end
    endcase
  end

endmodule

// File: tb/tb_weight_col_loader.sv
// tb/tb_weight_col_loader.sv - scoreboard bench for weight_col_loader
module tb_weight_col_loader;

  localparam int W_BITWIDTH = 8;
  localparam int ROWS       = 4;
`ifdef WLOAD_ZERO_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  s_valid;
  logic                  s_ready;
  logic [W_BITWIDTH-1:0] s_data;
  logic                  s_last;
  logic                  switch_allow;
  logic                  W_en;
  logic [W_BITWIDTH-1:0] W_out;
  logic                  switch_out;
  logic                  busy;
  logic                  err;

  weight_col_loader #(.W_BITWIDTH(W_BITWIDTH), .ROWS(ROWS)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .switch_allow(switch_allow),
    .W_en(W_en), .W_out(W_out), .switch_out(switch_out),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int                    cyc_e;
    logic [W_BITWIDTH-1:0] data_e;
  } beat_t;

  beat_t wq[$];
  int    swq[$];
  int    n_chk  = 0;
  int    n_fail = 0;
  int    t0     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (test cycle %0d)", name, act, exp, cyc - t0);
    end
  endtask

  // Monitor: every W_en beat and switch pulse must match the next queued expectation
  always @(negedge clk) begin
    beat_t b;
    int    sc;
    if (W_en === 1'b1) begin
      if (wq.size() == 0) begin
        check("w_en_unexpected", W_en, 1'b0);
      end else begin
        b = wq.pop_front();
        check("w_en_cycle", cyc - t0, b.cyc_e - t0);
        check("w_out", W_out, b.data_e);
      end
    end
    if (switch_out === 1'b1) begin
      if (swq.size() == 0) begin
        check("switch_unexpected", switch_out, 1'b0);
      end else begin
        sc = swq.pop_front();
        check("switch_cycle", cyc - t0, sc - t0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int rel);
    while (cyc - t0 < rel) tick();
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [W_BITWIDTH-1:0] d, input logic l);
    s_valid = v;
    s_data  = d;
    s_last  = l;
  endtask

  task automatic begin_test();
    t0 = cyc;
  endtask

  task automatic exp_w(input int rel, input logic [W_BITWIDTH-1:0] d);
    beat_t b;
    b.cyc_e  = t0 + rel;
    b.data_e = d;
    wq.push_back(b);
  endtask

  task automatic exp_sw(input int rel);
    swq.push_back(t0 + rel);
  endtask

  task automatic send_tile(input logic [W_BITWIDTH-1:0] d0, input logic [W_BITWIDTH-1:0] d1,
                           input logic [W_BITWIDTH-1:0] d2, input logic [W_BITWIDTH-1:0] d3,
                           input logic last_flag);
    goto(0); drive(1'b1, d0, 1'b0);
    goto(1); drive(1'b1, d1, 1'b0);
    goto(2); drive(1'b1, d2, 1'b0);
    goto(3); drive(1'b1, d3, last_flag);
    goto(4); drive(1'b0, '0, 1'b0);
  endtask

  task automatic drain(input int rel);
    goto(rel);
    sample();
    check("w_queue_empty", wq.size(), 0);
    check("switch_queue_empty", swq.size(), 0);
  endtask

  initial begin
    rst = 1'b1;
    switch_allow = 1'b0;
    drive(1'b0, '0, 1'b0);
    tick();
    tick();
    sample();
    check("rst_s_ready", s_ready, 1'b1);
    check("rst_w_en", W_en, 1'b0);
    check("rst_w_out", W_out, 8'h00);
    check("rst_switch", switch_out, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    tick();
    rst = 1'b0;
    tick();

    // Back-to-back tile, swap allowed immediately
    begin_test();
    switch_allow = 1'b1;
    exp_w(4, 8'h44); exp_w(5, 8'h33); exp_w(6, 8'h22); exp_w(7, 8'h11);
    exp_sw(13);
    send_tile(8'h11, 8'h22, 8'h33, 8'h44, 1'b1);
    sample();
    check("t1_s_ready_shift", s_ready, 1'b0);
    check("t1_busy_shift", busy, 1'b1);
    goto(14);
    sample();
    check("t1_s_ready_done", s_ready, 1'b1);
    check("t1_busy_done", busy, 1'b0);
    check("t1_err", err, 1'b0);
    drain(16);

    // Swap held off until cycle 20
    tick();
    begin_test();
    switch_allow = 1'b0;
    exp_w(4, 8'h44); exp_w(5, 8'h33); exp_w(6, 8'h22); exp_w(7, 8'h11);
    exp_sw(21);
    send_tile(8'h11, 8'h22, 8'h33, 8'h44, 1'b1);
    for (int c = 4; c <= 21; c++) begin
      goto(c);
      if (c == 20) switch_allow = 1'b1;
      sample();
      check("t2_s_ready_low", s_ready, 1'b0);
    end
    goto(22);
    sample();
    check("t2_s_ready_high", s_ready, 1'b1);
    drain(24);

    // Gapped input stream
    tick();
    begin_test();
    exp_w(10, 8'h04); exp_w(11, 8'h03); exp_w(12, 8'h02); exp_w(13, 8'h01);
    exp_sw(19);
    goto(0); drive(1'b1, 8'h01, 1'b0);
    goto(1); drive(1'b0, 8'hEE, 1'b1);
    goto(3); drive(1'b1, 8'h02, 1'b0);
    goto(4); drive(1'b1, 8'h03, 1'b0);
    goto(5); drive(1'b0, 8'hEE, 1'b0);
    sample();
    check("t3_busy_partial", busy, 1'b1);
    check("t3_s_ready_partial", s_ready, 1'b1);
    goto(9); drive(1'b1, 8'h04, 1'b1);
    goto(10); drive(1'b0, '0, 1'b0);
    drain(22);

    // Early s_last on the second word
    tick();
    begin_test();
    if (PAD) begin
      exp_w(2, 8'h00); exp_w(3, 8'h00); exp_w(4, 8'hBB); exp_w(5, 8'hAA);
      exp_sw(11);
    end
    goto(0); drive(1'b1, 8'hAA, 1'b0);
    goto(1); drive(1'b1, 8'hBB, 1'b1);
    goto(2); drive(1'b0, '0, 1'b0);
    sample();
    check("t4_err_after_short", err, PAD ? 1'b0 : 1'b1);
    check("t4_busy_after_short", busy, PAD ? 1'b1 : 1'b0);
    check("t4_s_ready_after_short", s_ready, PAD ? 1'b0 : 1'b1);
    drain(14);
    check("t4_busy_idle", busy, 1'b0);

    // Next full tile after the short one
    tick();
    begin_test();
    exp_w(4, 8'h88); exp_w(5, 8'h77); exp_w(6, 8'h66); exp_w(7, 8'h55);
    exp_sw(13);
    send_tile(8'h55, 8'h66, 8'h77, 8'h88, 1'b1);
    goto(14);
    sample();
    check("t4_err_sticky", err, PAD ? 1'b0 : 1'b1);
    drain(16);

    // Reset on the second shift cycle abandons the tile
    tick();
    begin_test();
    exp_w(4, 8'hC4); exp_w(5, 8'hC3);
    send_tile(8'hC1, 8'hC2, 8'hC3, 8'hC4, 1'b1);
    goto(5); rst = 1'b1;
    goto(6); rst = 1'b0;
    sample();
    check("t5_w_en", W_en, 1'b0);
    check("t5_switch", switch_out, 1'b0);
    check("t5_s_ready", s_ready, 1'b1);
    check("t5_busy", busy, 1'b0);
    check("t5_err_cleared", err, 1'b0);
    drain(25);

    // Full-length tile missing s_last still loads but flags err
    tick();
    begin_test();
    exp_w(4, 8'hD4); exp_w(5, 8'hD3); exp_w(6, 8'hD2); exp_w(7, 8'hD1);
    exp_sw(13);
    send_tile(8'hD1, 8'hD2, 8'hD3, 8'hD4, 1'b0);
    goto(14);
    sample();
    check("t6_err_no_last", err, 1'b1);
    drain(16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
